// File: rtl/pio_uart_rx_ctrl.sv
// Receive-side PIO controller: loads the uart_rx program and config, then drains SM0's RX FIFO
// one byte at a time and checks the received stream against an expected message.
module pio_uart_rx_ctrl #(
    // Word i of the program image sits at bits [16*i +: 16]; entry i of the config at [36*i +: 36].
    parameter logic [511:0]         PROG_IMAGE = {{27{16'h0000}}, 16'h8020, 16'h0642, 16'h4001,
                                                  16'hea27, 16'h2020},
    parameter logic [1151:0]        CONF_IMAGE = {{27{36'h0}}, 36'h7_0000_0001, 36'h6_0000_0000,
                                                  36'h4_0000_0001, 36'h3_0000_0000,
                                                  36'h2_0000_00d9},
    parameter int unsigned          CONF_LEN   = 5,
    parameter int unsigned          MSG_LEN    = 13,
    parameter logic [MSG_LEN*8-1:0] MSG        = "Hello World!\n",
    parameter int unsigned          BYTE_LSB   = 24
) (
    input  logic        clk_25mhz,
    input  logic        reset,
    input  logic [3:0]  rx_empty,
    input  logic [31:0] dout,
    output logic [31:0] din,
    output logic [4:0]  index,
    output logic [3:0]  action,
    output logic [1:0]  mindex,
    output logic        loaded,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic [7:0]  msg_count,
    output logic [7:0]  err_count
);

    localparam logic [3:0] ActNone  = 4'd0;
    localparam logic [3:0] ActInstr = 4'd1;
    localparam logic [3:0] ActPull  = 4'd5;
    localparam logic [5:0] ConfLen  = 6'(CONF_LEN);
    localparam logic [4:0] LastPtr  = 5'(MSG_LEN - 1);

    typedef enum logic [2:0] {
        StLoadProg,
        StLoadConf,
        StIdle,
        StPull,
        StCapture
    } state_e;

    state_e state_q, state_d;

    logic [4:0]  pindex_q, pindex_d;
    logic [5:0]  cindex_q, cindex_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [31:0] din_q, din_d;
    logic [4:0]  index_q, index_d;
    logic [3:0]  action_q, action_d;
    logic        loaded_q, loaded_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  msg_count_q, msg_count_d;
    logic [7:0]  err_count_q, err_count_d;

    logic [15:0] prog_rom  [32];
    logic [35:0] conf_rom  [32];
    logic [7:0]  msg_chars [32];
    logic [35:0] conf_word;
    logic [7:0]  rx_byte;
    logic [7:0]  exp_char;
    logic        unused_inputs;

    for (genvar i = 0; i < 32; i++) begin : g_rom
        assign prog_rom[i] = PROG_IMAGE[i*16 +: 16];
        assign conf_rom[i] = CONF_IMAGE[i*36 +: 36];
        if (i < MSG_LEN) begin : g_msg
            assign msg_chars[i] = MSG[(MSG_LEN-1-i)*8 +: 8];
        end else begin : g_pad
            assign msg_chars[i] = 8'h00;
        end
    end

    assign conf_word     = conf_rom[cindex_q[4:0]];
    assign rx_byte       = dout[BYTE_LSB +: 8];
    assign exp_char      = msg_chars[ptr_q];
    assign unused_inputs = ^{rx_empty[3:1], dout};

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state_q     <= StLoadProg;
            pindex_q    <= '0;
            cindex_q    <= '0;
            ptr_q       <= '0;
            din_q       <= '0;
            index_q     <= '0;
            action_q    <= ActNone;
            loaded_q    <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            msg_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pindex_q    <= pindex_d;
            cindex_q    <= cindex_d;
            ptr_q       <= ptr_d;
            din_q       <= din_d;
            index_q     <= index_d;
            action_q    <= action_d;
            loaded_q    <= loaded_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            msg_count_q <= msg_count_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StLoadProg: if (pindex_q == 5'd31) state_d = StLoadConf;
            StLoadConf: if (cindex_q >= ConfLen) state_d = StIdle;
            StIdle:     if (!rx_empty[0]) state_d = StPull;
            StPull:     state_d = StCapture;
            StCapture:  state_d = StIdle;
            default:    state_d = StLoadProg;
        endcase
    end

    // Outputs are registered, so the PULL strobe is launched on the IDLE->PULL transition and
    // is visible while in PULL; dout then lands while in CAPTURE.
    always_comb begin
        pindex_d    = pindex_q;
        cindex_d    = cindex_q;
        ptr_d       = ptr_q;
        din_d       = din_q;
        index_d     = index_q;
        action_d    = ActNone;
        loaded_d    = loaded_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        msg_count_d = msg_count_q;
        err_count_d = err_count_q;
        case (state_q)
            StLoadProg: begin
                action_d = ActInstr;
                index_d  = pindex_q;
                din_d    = {16'h0000, prog_rom[pindex_q]};
                pindex_d = pindex_q + 5'd1;
            end
            StLoadConf: begin
                if (cindex_q < ConfLen) begin
                    action_d = conf_word[35:32];
                    index_d  = cindex_q[4:0];
                    din_d    = conf_word[31:0];
                    cindex_d = cindex_q + 6'd1;
                end else begin
                    loaded_d = 1'b1;
                end
            end
            StIdle: begin
                if (!rx_empty[0]) action_d = ActPull;
            end
            StCapture: begin
                rx_data_d  = rx_byte;
                rx_valid_d = 1'b1;
                if (rx_byte == exp_char) begin
                    if (ptr_q == LastPtr) begin
                        ptr_d = 5'd0;
                        if (msg_count_q != 8'hff) msg_count_d = msg_count_q + 8'd1;
                    end else begin
                        ptr_d = ptr_q + 5'd1;
                    end
                end else begin
                    if (err_count_q != 8'hff) err_count_d = err_count_q + 8'd1;
                    // A mismatching byte may itself start a new message.
                    ptr_d = (rx_byte == msg_chars[0]) ? 5'd1 : 5'd0;
                end
            end
            default: ;
        endcase
    end

    assign din       = din_q;
    assign index     = index_q;
    assign action    = action_q;
    assign mindex    = 2'b00;
    assign loaded    = loaded_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign msg_count = msg_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_pio_uart_rx_ctrl.sv
// Scoreboard bench for pio_uart_rx_ctrl: a PIO FIFO model feeds bytes, a monitor checks load
// writes and received bytes against queued expectations.
module tb_pio_uart_rx_ctrl;

    localparam int ConfLen = 5;

    function automatic logic [15:0] prog_word(input int i);
        return 16'hA000 + 16'(i * 37);
    endfunction

    function automatic logic [35:0] conf_entry(input int i);
        return {4'(8 + i), 32'hC0DE_0000 + 32'(i)};
    endfunction

    function automatic logic [511:0] mk_prog();
        logic [511:0] r;
        for (int i = 0; i < 32; i++) r[i*16 +: 16] = prog_word(i);
        return r;
    endfunction

    function automatic logic [1151:0] mk_conf();
        logic [1151:0] r;
        for (int i = 0; i < 32; i++) r[i*36 +: 36] = conf_entry(i);
        return r;
    endfunction

    localparam logic [511:0]  TbProg = mk_prog();
    localparam logic [1151:0] TbConf = mk_conf();

    logic        clk_25mhz = 1'b0;
    logic        reset     = 1'b1;
    logic [3:0]  rx_empty  = 4'hF;
    logic [31:0] dout      = 32'h0;
    logic [31:0] din;
    logic [4:0]  index;
    logic [3:0]  action;
    logic [1:0]  mindex;
    logic        loaded;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  msg_count;
    logic [7:0]  err_count;

    typedef struct packed {
        logic [3:0]  act;
        logic [4:0]  idx;
        logic [31:0] data;
        logic        chk_idx;
    } wr_t;

    logic [7:0] pio_fifo [$];
    logic [7:0] exp_q [$];
    wr_t        load_q [$];
    int         valid_times [$];
    int         cyc = 0;
    int         last_pull = 0;
    int         nvalid = 0;
    int         checks = 0;
    int         errors = 0;

    pio_uart_rx_ctrl #(
        .PROG_IMAGE(TbProg),
        .CONF_IMAGE(TbConf),
        .CONF_LEN  (ConfLen),
        .MSG_LEN   (13),
        .MSG       ("Hello World!\n"),
        .BYTE_LSB  (24)
    ) dut (
        .clk_25mhz(clk_25mhz),
        .reset    (reset),
        .rx_empty (rx_empty),
        .dout     (dout),
        .din      (din),
        .index    (index),
        .action   (action),
        .mindex   (mindex),
        .loaded   (loaded),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .msg_count(msg_count),
        .err_count(err_count)
    );

    always #20 clk_25mhz = ~clk_25mhz;
    always @(posedge clk_25mhz) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // PIO model: a PULL seen at a clock edge pops the FIFO; dout valid from just after that edge.
    initial begin
        logic pulled;
        forever begin
            @(posedge clk_25mhz);
            pulled = (action == 4'd5) && !reset;
            #1;
            if (pulled) begin
                if (pio_fifo.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pull_from_empty_fifo: PULL issued with empty FIFO (cycle %0d)", cyc);
                end else begin
                    dout = {pio_fifo.pop_front(), 24'hA55A3C};
                end
            end
            rx_empty = {3'b111, pio_fifo.size() == 0};
        end
    end

    // Monitor: compares every load write and every received byte against the queues.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk_25mhz);
            if (!reset) begin
                if (action == 4'd5) begin
                    check("pull_after_load", 64'(loaded), 64'd1);
                    last_pull = cyc;
                end else if (action != 4'd0) begin
                    if (load_q.size() == 0) begin
                        check("unexpected_write", 64'(action), 64'd0);
                    end else begin
                        w = load_q.pop_front();
                        check("wr_action", 64'(action), 64'(w.act));
                        check("wr_din", 64'(din), 64'(w.data));
                        if (w.chk_idx) check("wr_index", 64'(index), 64'(w.idx));
                    end
                end
            end
            if (rx_valid) begin
                nvalid++;
                valid_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_rx_valid", 64'(rx_valid), 64'd0);
                end else begin
                    check("rx_data", 64'(rx_data), 64'(exp_q.pop_front()));
                    check("rx_latency", 64'(cyc - last_pull), 64'd2);
                end
            end
        end
    end

    task automatic feed(input logic [7:0] b);
        pio_fifo.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic feed_str(input string s);
        for (int i = 0; i < s.len(); i++) feed(s[i]);
    endtask

    // Called on a falling edge; reset takes effect at the next rising edge.
    task automatic do_reset_and_load(input bit feed_h);
        wr_t w;
        reset = 1'b1;
        pio_fifo.delete();
        exp_q.delete();
        load_q.delete();
        repeat (3) @(negedge clk_25mhz);
        check("reset_ctrl", 64'({din, index, action, mindex, loaded}), 64'd0);
        check("reset_rx", 64'({rx_data, rx_valid, msg_count, err_count}), 64'd0);
        for (int i = 0; i < 32; i++) begin
            w = '{act: 4'd1, idx: 5'(i), data: {16'h0, prog_word(i)}, chk_idx: 1'b1};
            load_q.push_back(w);
        end
        for (int i = 0; i < ConfLen; i++) begin
            w = '{act: conf_entry(i)[35:32], idx: 5'(i), data: conf_entry(i)[31:0], chk_idx: 1'b0};
            load_q.push_back(w);
        end
        @(posedge clk_25mhz);
        #1 reset = 1'b0;
        if (feed_h) feed(8'h48);
        repeat (37) @(posedge clk_25mhz);
        @(negedge clk_25mhz);
        check("loaded_before_38", 64'(loaded), 64'd0);
        @(negedge clk_25mhz);
        check("loaded_at_38", 64'(loaded), 64'd1);
        check("action_at_38", 64'(action), 64'd0);
        check("load_words_consumed", 64'(load_q.size()), 64'd0);
    endtask

    task automatic wait_drain(input string name, input int max);
        int n = 0;
        while ((exp_q.size() != 0 || pio_fifo.size() != 0) && n < max) begin
            @(negedge clk_25mhz);
            n++;
        end
        repeat (4) @(negedge clk_25mhz);
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int bad;
        int base;
        int n;

        // Load sequence, with a byte already waiting that must not be pulled until loaded.
        do_reset_and_load(1'b1);
        wait_drain("single_h", 50);
        check("single_h_msg", 64'(msg_count), 64'd0);
        check("single_h_err", 64'(err_count), 64'd0);

        // Two back-to-back messages.
        do_reset_and_load(1'b0);
        valid_times.delete();
        feed_str("Hello World!\n");
        feed_str("Hello World!\n");
        wait_drain("two_msgs", 200);
        check("two_msgs_msg", 64'(msg_count), 64'd2);
        check("two_msgs_err", 64'(err_count), 64'd0);
        check("two_msgs_pulses", 64'(valid_times.size()), 64'd26);
        bad = 0;
        for (int i = 1; i < valid_times.size(); i++)
            if (valid_times[i] - valid_times[i-1] != 3) bad++;
        check("two_msgs_spacing", 64'(bad), 64'd0);

        // Corrupted prefix then a full message.
        do_reset_and_load(1'b0);
        feed_str("HeXHello World!\n");
        wait_drain("resync", 200);
        check("resync_err", 64'(err_count), 64'd1);
        check("resync_msg", 64'(msg_count), 64'd1);

        // Reset while a PULL is outstanding after 7 bytes.
        do_reset_and_load(1'b0);
        base = nvalid;
        feed_str("Hello World!\n");
        n = 0;
        while (nvalid < base + 7 && n < 100) begin
            @(negedge clk_25mhz);
            n++;
        end
        check("abort_seven_bytes", 64'(nvalid - base), 64'd7);
        n = 0;
        while (action != 4'd5 && n < 20) begin
            @(negedge clk_25mhz);
            n++;
        end
        check("abort_in_pull", 64'(action), 64'd5);
        do_reset_and_load(1'b0);
        repeat (10) @(negedge clk_25mhz);
        check("abort_no_valid", 64'(nvalid - base), 64'd7);
        check("abort_msg", 64'(msg_count), 64'd0);
        check("abort_err", 64'(err_count), 64'd0);

        // Error counter saturation.
        for (int i = 0; i < 300; i++) feed(8'h00);
        wait_drain("saturate", 1200);
        check("saturate_err", 64'(err_count), 64'd255);
        check("saturate_msg", 64'(msg_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(40 * 20000);
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
